cm_sort_arb: RTL and testbench

// - Round-robin scheduler sharing one cm_sort pipeline between RCNT requesters.
// - Tags each issued vector with its requester ID and tracks it through the fixed-latency sort.
// - Returns sorted vectors on one valid/ready output channel through a credit-guarded FIFO.
// - The sort pipeline has no backpressure, so issue is throttled by credits.

---
 rtl/cm_pkg.sv | 25 ++
 rtl/cm_rr_arb.sv | 52 +++++
 rtl/cm_sort_arb.sv | 186 ++++++++++++++++++
 tb/tb_cm_sort_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// rtl/cm_pkg.sv - shared widths and FIFO entry type for the cm_sort arbiter
//
// Purpose: default vector geometry, the requester-ID width function and the
// output FIFO entry layout {id, data} used by cm_sort_arb.
// Ports: none (package).
// The entry struct is sized from CM_RCNT/CM_DCNT/CM_DWIDTH, so a different
// geometry is selected by changing these constants rather than by overriding
// parameters on a single instance.
package cm_pkg;

  localparam int CM_RCNT   = 4;
  localparam int CM_DCNT   = 8;
  localparam int CM_DWIDTH = 8;

  // Requester-ID width; a single requester still needs a 1-bit field.
  function automatic int cm_id_w(input int rcnt);
    return (rcnt > 1) ? $clog2(rcnt) : 1;
  endfunction

  typedef struct packed {
    logic [cm_id_w(CM_RCNT)-1:0]    id;
    logic [CM_DCNT*CM_DWIDTH-1:0]   data;
  } cm_entry_t;

endpackage

// File: rtl/cm_rr_arb.sv
// rtl/cm_rr_arb.sv - round-robin arbiter with rotating priority pointer
//
// Purpose: grants the first requesting index at or above ptr (wrapping).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   req       request vector
//   en        grant is consumed this cycle (advances ptr when a request wins)
//   gnt       one-hot grant (combinational, independent of en)
//   gnt_id    binary index of gnt
module cm_rr_arb
  import cm_pkg::*;
#(
  parameter  int RCNT = 4,
  localparam int IDW  = cm_id_w(RCNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RCNT-1:0] req,
  input  logic            en,
  output logic [RCNT-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < RCNT; i++) begin
      idx = IDW'((int'(ptr) + i) % RCNT);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  // Priority moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_id == IDW'(RCNT - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

endmodule

// File: rtl/cm_sort_arb.sv
// rtl/cm_sort_arb.sv - round-robin, credit-throttled front end sharing one cm_sort
//
// Purpose: arbitrates RCNT requesters onto a fixed-latency cm_sort pipeline,
// tags each vector with its requester ID and returns results in issue order
// through a first-word-fall-through FIFO.
// Optional: CM_SORT_ARB_STAT_EN adds o_gnt_cnt / o_stall_cnt statistics.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req_vld      per-requester valid
//   i_req_data     per-requester vectors [RCNT][DCNT][DWIDTH]
//   o_req_rdy      one-hot accept
//   o_sort_vld     issue strobe to cm_sort
//   o_sort_data    registered vector to cm_sort
//   i_sort_vld     cm_sort result valid
//   i_sort_data    cm_sort result vector
//   o_vld, o_id, o_data, i_rdy   result channel (FIFO head)
//   o_err          sticky return-path error
//   o_gnt_cnt      per-requester handshake counters (stat build only)
//   o_stall_cnt    credit-blocked request cycles (stat build only)
module cm_sort_arb
  import cm_pkg::*;
#(
  parameter  int RCNT       = CM_RCNT,
  parameter  int DCNT       = CM_DCNT,
  parameter  int DWIDTH     = CM_DWIDTH,
  parameter  int SORT_LAT   = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = cm_id_w(RCNT),
  localparam int DW         = DCNT * DWIDTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [RCNT-1:0]                     i_req_vld,
  input  logic [RCNT-1:0][DCNT-1:0][DWIDTH-1:0] i_req_data,
  output logic [RCNT-1:0]                     o_req_rdy,
  output logic                                o_sort_vld,
  output logic [DW-1:0]                       o_sort_data,
  input  logic                                i_sort_vld,
  input  logic [DW-1:0]                       i_sort_data,
  output logic                                o_vld,
  output logic [IDW-1:0]                      o_id,
  output logic [DW-1:0]                       o_data,
  input  logic                                i_rdy,
  output logic                                o_err
`ifdef CM_SORT_ARB_STAT_EN
  ,
  output logic [RCNT-1:0][15:0]               o_gnt_cnt,
  output logic [15:0]                         o_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [RCNT-1:0]               gnt;
  logic [IDW-1:0]                gnt_id;
  logic                          credit;
  logic                          hs;
  logic [CW-1:0]                 fifo_cnt;
  logic [CW-1:0]                 inflight;
  logic [IDW-1:0]                issue_id;
  logic [SORT_LAT-1:0]           tag_vld;
  logic [SORT_LAT-1:0][IDW-1:0]  tag_id;
  logic                          tag_out_vld;
  logic [IDW-1:0]                tag_out_id;
  cm_entry_t                     mem [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr;
  logic [PW-1:0]                 rd_ptr;
  logic                          full;
  logic                          push_ok;
  logic                          pop;

  // Registered counts only: a pop returns its credit one cycle later.
  // inflight counts from the handshake, so the issue register is covered too.
  assign credit    = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
  assign hs        = credit & (|i_req_vld);
  assign o_req_rdy = credit ? gnt : '0;

  cm_rr_arb #(.RCNT(RCNT)) u_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (i_req_vld),
    .en     (credit),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sort_vld  <= 1'b0;
      o_sort_data <= '0;
      issue_id    <= '0;
    end else begin
      o_sort_vld <= hs;
      if (hs) begin
        o_sort_data <= i_req_data[gnt_id];
        issue_id    <= gnt_id;
      end
    end
  end

  // Tag pipe runs alongside cm_sort: stage 0 holds what cm_sort just received.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= o_sort_vld;
      tag_id[0]  <= issue_id;
      for (int i = 1; i < SORT_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign tag_out_vld = tag_vld[SORT_LAT-1];
  assign tag_out_id  = tag_id[SORT_LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(hs) - CW'(tag_out_vld);
    end
  end

  assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
  assign o_vld   = (fifo_cnt != '0);
  assign pop     = o_vld & i_rdy;
  assign push_ok = i_sort_vld & ~full;
  assign o_id    = mem[rd_ptr].id;
  assign o_data  = mem[rd_ptr].data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{id: tag_out_id, data: i_sort_data};
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push_ok) - CW'(pop);
    end
  end

  // Any return strobe not matched by a tag (or vice versa), or a push into a
  // full FIFO, means cm_sort and this block have lost step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if ((i_sort_vld != tag_out_vld) || (i_sort_vld && full)) begin
      o_err <= 1'b1;
    end
  end

`ifdef CM_SORT_ARB_STAT_EN
  logic stall;
  assign stall = (|i_req_vld) & ~credit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      for (int r = 0; r < RCNT; r++) begin
        if (o_req_rdy[r] && i_req_vld[r] && (o_gnt_cnt[r] != 16'hFFFF)) begin
          o_gnt_cnt[r] <= o_gnt_cnt[r] + 16'd1;
        end
      end
      if (stall && (o_stall_cnt != 16'hFFFF)) begin
        o_stall_cnt <= o_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cm_sort_arb.sv
// tb/tb_cm_sort_arb.sv - directed self-checking bench for cm_sort_arb
module tb_cm_sort_arb;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            req_vld;
  logic [3:0][7:0][7:0]  req_data;
  logic [3:0]            req_rdy;
  logic                  sort_vld_o;
  logic [63:0]           sort_data_o;
  logic                  sort_vld_i;
  logic [63:0]           sort_data_i;
  logic                  vld;
  logic [1:0]            id;
  logic [63:0]           data;
  logic                  rdy;
  logic                  err;
  logic                  inject;
  logic                  sv_q;
  logic [63:0]           sd_q;
`ifdef CM_SORT_ARB_STAT_EN
  logic [3:0][15:0]      gnt_cnt;
  logic [15:0]           stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cm_sort_arb dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_vld   (req_vld),
    .i_req_data  (req_data),
    .o_req_rdy   (req_rdy),
    .o_sort_vld  (sort_vld_o),
    .o_sort_data (sort_data_o),
    .i_sort_vld  (sort_vld_i),
    .i_sort_data (sort_data_i),
    .o_vld       (vld),
    .o_id        (id),
    .o_data      (data),
    .i_rdy       (rdy),
    .o_err       (err)
`ifdef CM_SORT_ARB_STAT_EN
    ,
    .o_gnt_cnt   (gnt_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  // Stand-in cm_sort: one register stage, ascending order (element 0 smallest).
  function automatic logic [63:0] sort_fn(input logic [63:0] v);
    logic [7:0] a [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sv_q <= 1'b0;
      sd_q <= '0;
    end else begin
      sv_q <= sort_vld_o;
      sd_q <= sort_fn(sort_data_o);
    end
  end

  assign sort_vld_i  = sv_q | inject;
  assign sort_data_i = sd_q;

  // Requester r carries r*16+7-i at element i, so its sorted form is r*16+i.
  function automatic logic [63:0] exp_sorted(input int r);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(r * 16 + i);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    rdy      = 1'b0;
    inject   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt;
    int pops;
    logic [63:0] vec;

    // Reset: idle outputs for 10 cycles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      check("reset_rdy", 64'(req_rdy), 64'h0);
      check("reset_sort_vld", 64'(sort_vld_o), 64'h0);
      check("reset_vld", 64'(vld), 64'h0);
      check("reset_err", 64'(err), 64'h0);
      tick();
    end

    // Round-robin: grants 0,1,2,3,... and o_id follows three cycles later
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) req_data[r][i] = 8'(r * 16 + 7 - i);
    req_vld = 4'hF;
    rdy     = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("rr_grant", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
      if (k >= 3) begin
        check("rr_out_vld", 64'(vld), 64'h1);
        check("rr_out_id", 64'(id), 64'((k - 3) % 4));
      end
      tick();
    end

    // Sort data: requester 2, result at handshake + 3
    do_reset();
    vec = 64'h0103A00005020301;
    req_data[2] = vec;
    req_vld = 4'b0100;
    #1;
    check("sd_grant", 64'(req_rdy), 64'h4);
    tick();
    req_vld = '0;
    #1;
    check("sd_issue_vld", 64'(sort_vld_o), 64'h1);
    check("sd_issue_data", sort_data_o, vec);
    tick();
    #1;
    check("sd_not_yet", 64'(vld), 64'h0);
    tick();
    #1;
    check("sd_vld", 64'(vld), 64'h1);
    check("sd_id", 64'(id), 64'h2);
    check("sd_data", data, 64'hA005030302010100);
    rdy = 1'b1;
    tick();
    #1;
    check("sd_drained", 64'(vld), 64'h0);
    check("sd_err", 64'(err), 64'h0);

    // Backpressure: FIFO_DEPTH handshakes, then credit blocks until pops
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) req_data[r][i] = 8'(r * 16 + 7 - i);
    req_vld = 4'hF;
    hs_cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (|(req_rdy & req_vld)) hs_cnt++;
      check("bp_grant", 64'(req_rdy), (k < 4) ? 64'(4'b0001 << k) : 64'h0);
      tick();
    end
    check("bp_hs_count", 64'(hs_cnt), 64'h4);
    check("bp_full_vld", 64'(vld), 64'h1);
    rdy  = 1'b1;
    pops = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (j == 0) check("bp_credit_late", 64'(req_rdy), 64'h0);
      if (j == 1) check("bp_credit_back", 64'(req_rdy), 64'h1);
      if (vld) begin
        check("bp_pop_id", 64'(id), 64'(pops % 4));
        check("bp_pop_data", data, exp_sorted(pops % 4));
        pops++;
      end
      tick();
    end
    check("bp_pop_count", 64'(pops), 64'h8);
    check("bp_err", 64'(err), 64'h0);

    // Error detection: spurious return strobe with empty tag pipe
    do_reset();
    #1;
    check("err_clear", 64'(err), 64'h0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #1;
    check("err_set", 64'(err), 64'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("err_sticky", 64'(err), 64'h1);
    end
    do_reset();
    #1;
    check("err_reset", 64'(err), 64'h0);

`ifdef CM_SORT_ARB_STAT_EN
    // Statistics: five handshakes from requester 1 only
    do_reset();
    rdy     = 1'b1;
    req_vld = 4'b0010;
    for (int k = 0; k < 5; k++) tick();
    req_vld = '0;
    #1;
    for (int r = 0; r < 4; r++)
      check("stat_gnt_cnt", 64'(gnt_cnt[r]), (r == 1) ? 64'd5 : 64'd0);
    check("stat_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
